// File: rtl/riscv_ctrl_pkg.sv
// Package for the multicycle RISC-V control FSM.
// Holds the state encoding, the opcodes the decoder recognises, and the
// ALU-operation and datapath-select encodings driven by the controller.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEMADR   = 4'h2,
    S_MEMREAD  = 4'h3,
    S_MEMWB    = 4'h4,
    S_MEMWRITE = 4'h5,
    S_EXECUTER = 4'h6,
    S_EXECUTEI = 4'h7,
    S_ALUWB    = 4'h8,
    S_JAL      = 4'h9,
    S_BEQ      = 4'hA,
    S_ILLEGAL  = 4'hB
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU source B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: sequences FETCH/DECODE and the
// per-class execute states, producing datapath strobes and mux selects.
//
// Parameters
//   MEM_HANDSHAKE  1: memory states wait for mem_ready; 0: mem_ready treated as 1
//   ENABLE_JAL     1: opcode 1101111 decoded as JAL; 0: treated as illegal
// Ports
//   clk, rst_n            clock, async active-low reset
//   opcode[6:0]           from instruction register, stable after FETCH
//   mem_ready             memory transfer completes this cycle
//   zero                  ALU zero flag (branch resolution)
//   pc_en                 PC write enable = pc_update | (branch & zero)
//   ir_write, mem_read, mem_write, reg_write, adr_src, branch  strobes/selects
//   alu_src_a, alu_src_b, result_src, alu_op                   2-bit selects
//   illegal               sticky illegal-opcode flag
//   state[3:0]            current state, for debug
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction, PC+4; wait for mem_ready
// DECODE   | compute branch/jump target (oldPC + imm)
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | read data memory; wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | write data memory; wait for mem_ready
// EXECUTER | ALU rs1 op rs2
// EXECUTEI | ALU rs1 op imm
// ALUWB    | write ALU result to rd
// JAL      | PC <- target, compute return address oldPC + 4
// BEQ      | compare rs1/rs2, PC <- target when zero
// ILLEGAL  | unrecognised opcode; held until reset
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ENABLE_JAL    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_rdy;
  logic   pc_update;

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = (ENABLE_JAL != 0) ? S_JAL : S_ILLEGAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  // While rst_n is low state_q already reads FETCH, so only the
  // write-type strobes need explicit gating against the reset pin.
  always_comb begin
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    branch     = 1'b0;
    pc_update  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_rdy;
        pc_update  = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
    ir_write  = ir_write & rst_n;
    mem_write = mem_write & rst_n;
    reg_write = reg_write & rst_n;
    pc_en     = (pc_update | (branch & zero)) & rst_n;
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, ER = 4'd6, EI = 4'd7, AWB = 4'd8,
                         J = 4'd9, B = 4'd10, IL = 4'd11;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         SYS = 7'b1110011;

  typedef struct {
    int          dut;
    logic [3:0]  st;
    logic [15:0] outs;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn [3];
  logic [6:0] op   [3];
  logic       mr   [3];
  logic       z    [3];

  logic [3:0]  act_st  [3];
  logic [15:0] act_out [3];

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pc_en, ir_write, mem_read, mem_write, reg_write, adr_src, branch, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [3:0] state;
    multicycle_control #(
      .MEM_HANDSHAKE((g == 2) ? 0 : 1),
      .ENABLE_JAL   ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rstn[g]),
      .opcode    (op[g]),
      .mem_ready (mr[g]),
      .zero      (z[g]),
      .pc_en     (pc_en),
      .ir_write  (ir_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .reg_write (reg_write),
      .adr_src   (adr_src),
      .branch    (branch),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .result_src(result_src),
      .alu_op    (alu_op),
      .illegal   (illegal),
      .state     (state)
    );
    assign act_st[g]  = state;
    assign act_out[g] = {mem_read, mem_write, reg_write, ir_write, pc_en, illegal,
                         adr_src, branch, alu_src_a, alu_src_b, result_src, alu_op};
  end

  // Expected outputs per state, written from the state/output table.
  function automatic logic [15:0] model(input logic [3:0] st, input logic m,
                                        input logic zz, input logic r);
    logic rd = 0, wr = 0, rw = 0, irw = 0, pce = 0, ill = 0, adr = 0, br = 0;
    logic [1:0] a = 0, b = 0, res = 0, alu = 0;
    case (st)
      F:   begin rd = 1; b = 2'b10; res = 2'b10; irw = m & r; pce = m & r; end
      D:   begin a = 2'b01; b = 2'b01; end
      MA:  begin a = 2'b10; b = 2'b01; end
      MR:  begin adr = 1; rd = 1; end
      MWB: begin res = 2'b01; rw = 1; end
      MW:  begin adr = 1; wr = 1; end
      ER:  begin a = 2'b10; alu = 2'b10; end
      EI:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      AWB: rw = 1;
      J:   begin a = 2'b01; b = 2'b10; pce = 1; end
      B:   begin a = 2'b10; alu = 2'b01; br = 1; pce = zz; end
      IL:  ill = 1;
      default: ;
    endcase
    return {rd, wr, rw, irw, pce, ill, adr, br, a, b, res, alu};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input int d, input logic [3:0] st, input logic [6:0] o,
                      input logic m, input logic zz, input logic r, input string nm);
    exp_t e;
    op[d] = o; mr[d] = m; z[d] = zz; rstn[d] = r;
    e.dut = d; e.st = st; e.name = nm;
    e.outs = model(st, (d == 2) ? 1'b1 : m, zz, r);
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      tests++;
      if (act_st[mon_e.dut] !== mon_e.st || act_out[mon_e.dut] !== mon_e.outs) begin
        fails++;
        $display("FAIL %s: dut%0d got state=%0d outs=%h, expected state=%0d outs=%h",
                 mon_e.name, mon_e.dut, act_st[mon_e.dut], act_out[mon_e.dut],
                 mon_e.st, mon_e.outs);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; op[i] = '0; mr[i] = 1'b0; z[i] = 1'b0;
    end
    @(posedge clk); #1;

    step(0, F,   RT, 1, 0, 0, "reset_forces_fetch");
    // R-type
    step(0, F,   RT, 1, 0, 1, "r_fetch");
    step(0, D,   RT, 1, 0, 1, "r_decode");
    step(0, ER,  RT, 1, 0, 1, "r_exec");
    step(0, AWB, RT, 1, 0, 1, "r_aluwb");
    // I-type
    step(0, F,   IT, 1, 0, 1, "i_fetch");
    step(0, D,   IT, 1, 0, 1, "i_decode");
    step(0, EI,  IT, 1, 0, 1, "i_exec");
    step(0, AWB, IT, 1, 0, 1, "i_aluwb");
    // Load with two wait cycles: 7 cycles
    step(0, F,   LD, 1, 0, 1, "ld_fetch");
    step(0, D,   LD, 1, 0, 1, "ld_decode");
    step(0, MA,  LD, 1, 0, 1, "ld_memadr");
    step(0, MR,  LD, 0, 0, 1, "ld_memread_wait1");
    step(0, MR,  LD, 0, 0, 1, "ld_memread_wait2");
    step(0, MR,  LD, 1, 0, 1, "ld_memread_done");
    step(0, MWB, LD, 1, 0, 1, "ld_memwb");
    // Store with one wait cycle
    step(0, F,   ST, 1, 0, 1, "st_fetch");
    step(0, D,   ST, 1, 0, 1, "st_decode");
    step(0, MA,  ST, 1, 0, 1, "st_memadr");
    step(0, MW,  ST, 0, 0, 1, "st_memwrite_wait");
    step(0, MW,  ST, 1, 0, 1, "st_memwrite_done");
    // Branch taken / not taken
    step(0, F,   BQ, 1, 0, 1, "beq1_fetch");
    step(0, D,   BQ, 1, 0, 1, "beq1_decode");
    step(0, B,   BQ, 1, 1, 1, "beq_taken");
    step(0, F,   BQ, 1, 0, 1, "beq0_fetch");
    step(0, D,   BQ, 1, 1, 1, "beq0_decode");
    step(0, B,   BQ, 1, 0, 1, "beq_not_taken");
    // JAL
    step(0, F,   JL, 1, 0, 1, "jal_fetch");
    step(0, D,   JL, 1, 0, 1, "jal_decode");
    step(0, J,   JL, 0, 0, 1, "jal_state");
    step(0, AWB, JL, 1, 0, 1, "jal_aluwb");
    // Fetch wait, then reset mid-store during a memory wait
    step(0, F,   ST, 0, 0, 1, "fetch_wait");
    step(0, F,   ST, 1, 0, 1, "rst_st_fetch");
    step(0, D,   ST, 1, 0, 1, "rst_st_decode");
    step(0, MA,  ST, 1, 0, 1, "rst_st_memadr");
    step(0, MW,  ST, 0, 0, 1, "rst_st_memwrite");
    step(0, F,   ST, 1, 0, 0, "rst_st_abandon");
    step(0, F,   ST, 0, 0, 1, "rst_st_resume_wait");
    step(0, F,   IT, 1, 0, 1, "rst_st_resume_fetch");
    step(0, D,   IT, 1, 0, 1, "rst_st_resume_decode");
    // Illegal opcode, sticky until reset
    step(0, EI,  SYS, 1, 0, 1, "ill_prev_exec");
    step(0, AWB, SYS, 1, 0, 1, "ill_prev_aluwb");
    step(0, F,   SYS, 1, 0, 1, "ill_fetch");
    step(0, D,   SYS, 1, 0, 1, "ill_decode");
    step(0, IL,  RT,  1, 1, 1, "ill_state");
    step(0, IL,  LD,  1, 0, 1, "ill_sticky");
    step(0, F,   LD,  1, 0, 0, "ill_cleared_by_reset");

    // ENABLE_JAL = 0: JAL opcode is illegal
    step(1, F,   JL, 1, 0, 0, "nj_reset");
    step(1, F,   JL, 1, 0, 1, "nj_fetch");
    step(1, D,   JL, 1, 0, 1, "nj_decode");
    step(1, IL,  JL, 1, 0, 1, "nj_illegal");
    step(1, IL,  RT, 1, 0, 1, "nj_sticky");

    // MEM_HANDSHAKE = 0 with mem_ready held low: store in 4 cycles
    step(2, F,   ST, 0, 0, 0, "nh_reset");
    step(2, F,   ST, 0, 0, 1, "nh_fetch");
    step(2, D,   ST, 0, 0, 1, "nh_decode");
    step(2, MA,  ST, 0, 0, 1, "nh_memadr");
    step(2, MW,  ST, 0, 0, 1, "nh_memwrite");
    step(2, F,   ST, 0, 0, 1, "nh_next_fetch");

    @(negedge clk); @(negedge clk);
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
